// File: rtl/nios_system_cpu_dct_ctrl_pkg.sv
// Purpose: shared constants, FSM state type and packed output word for the
//          Nios OCI debug-capture-trace packer.
// Contents: SYM_W/DEPTH/BUF_W/CNT_W widths, dct_state_e, dct_word_t.
package nios_dct_pkg;

  localparam int unsigned SYM_W = 2;
  localparam int unsigned DEPTH = 15;
  localparam int unsigned BUF_W = SYM_W * DEPTH;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    HOLD,
    DRAIN,
    ENDED
  } dct_state_e;

  // One packed word as handed downstream.
  typedef struct packed {
    logic [CNT_W-1:0] count;
    logic [BUF_W-1:0] data;
  } dct_word_t;

endpackage

// File: rtl/nios_system_cpu_dct_ctrl_if.sv
// Purpose: symbol-in / packed-word-out handshake bundle of the DCT packer.
// Signals: sym_valid/sym_data/sym_ready (symbol link),
//          out_valid/out_ready/out_data/out_count (packed word link).
// Modports: master = trace source + downstream sink, slave = packer.
interface nios_system_cpu_dct_ctrl_if;
  import nios_dct_pkg::*;

  logic             sym_valid;
  logic [SYM_W-1:0] sym_data;
  logic             sym_ready;
  logic             out_valid;
  logic             out_ready;
  logic [BUF_W-1:0] out_data;
  logic [CNT_W-1:0] out_count;

  modport master (
    output sym_valid, sym_data, out_ready,
    input  sym_ready, out_valid, out_data, out_count
  );

  modport slave (
    input  sym_valid, sym_data, out_ready,
    output sym_ready, out_valid, out_data, out_count
  );

endinterface

// File: rtl/nios_system_cpu_dct_outreg.sv
// Purpose: valid/ready holding register for completed packed words.
// Ports: clk, reset (async, active-high); load/word_in from the packer;
//        out_ready from downstream; out_valid/word_out held until taken;
//        free_c is high when a new word may be loaded this cycle.
module nios_system_cpu_dct_outreg
  import nios_dct_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      load,
  input  dct_word_t word_in,
  input  logic      out_ready,
  output logic      out_valid,
  output dct_word_t word_out,
  output logic      free_c
);

  assign free_c = ~out_valid | out_ready;

  // Load has priority; the caller only loads when free_c is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      word_out  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      word_out  <= word_in;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/nios_system_cpu_dct_ctrl.sv
// Purpose: packs 2-bit trace symbols into 15-symbol words, hands them to the
//          output register, sequences flushes and the end-of-test drain.
// Ports: clk, reset (async, active-high); trace_en, flush, test_ending,
//        overflow_clr controls; bus (slave) carries the symbol and word
//        handshakes; dct_buffer/dct_count expose the live fill buffer;
//        overflow (sticky drop flag); test_has_ended (sticky drain done).
module nios_system_cpu_dct_ctrl
  import nios_dct_pkg::*;
#(
  parameter bit DROP_ON_FULL = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       trace_en,
  input  logic                       flush,
  input  logic                       test_ending,
  input  logic                       overflow_clr,
  nios_system_cpu_dct_ctrl_if.slave  bus,
  output logic [BUF_W-1:0]           dct_buffer,
  output logic [CNT_W-1:0]           dct_count,
  output logic                       overflow,
  output logic                       test_has_ended
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  dct_state_e       state_q, state_d;
  logic [BUF_W-1:0] buf_q, buf_d, merged_buf;
  logic [CNT_W-1:0] cnt_q, cnt_d, merged_cnt;
  logic             flush_req_q, flush_req_d;
  logic             overflow_q, overflow_d;
  logic             full, active, free_c, ready, accept, fits;
  logic             force_flush, handoff, drop;
  logic             out_valid;
  dct_word_t        load_word, out_word;

  nios_system_cpu_dct_outreg u_outreg (
    .clk       (clk),
    .reset     (reset),
    .load      (handoff),
    .word_in   (load_word),
    .out_ready (bus.out_ready),
    .out_valid (out_valid),
    .word_out  (out_word),
    .free_c    (free_c)
  );

  assign bus.sym_ready  = ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = out_word.data;
  assign bus.out_count  = out_word.count;
  assign dct_buffer     = buf_q;
  assign dct_count      = cnt_q;
  assign overflow       = overflow_q;
  assign test_has_ended = (state_q == ENDED);

  // Accept/handoff decision, next fill buffer and next FSM state.
  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    merged_buf  = buf_q;
    merged_cnt  = cnt_q;
    flush_req_d = 1'b0;
    overflow_d  = overflow_q;
    load_word   = '0;

    full   = (cnt_q == FULL_CNT);
    active = (state_q != DRAIN) && (state_q != ENDED);
    // A full buffer can still take a symbol when it is handed off this cycle.
    ready  = ~reset & trace_en & ~test_ending & active & (~full | free_c | DROP_ON_FULL);
    accept = bus.sym_valid & ready;
    fits   = accept & ~full;

    if (fits) begin
      merged_buf[SYM_W * 32'(cnt_q) +: SYM_W] = bus.sym_data;
      merged_cnt = cnt_q + CNT_W'(1);
    end

    force_flush = flush | flush_req_q | test_ending | (state_q == DRAIN);
    handoff     = (merged_cnt != '0) & ((merged_cnt == FULL_CNT) | force_flush) & free_c;
    drop        = accept & full & ~handoff;

    load_word.count = merged_cnt;
    load_word.data  = merged_buf;

    buf_d = merged_buf;
    cnt_d = merged_cnt;
    if (handoff) begin
      buf_d = '0;
      cnt_d = '0;
      // Symbol taken while full starts the next word.
      if (accept & full) begin
        buf_d[SYM_W-1:0] = bus.sym_data;
        cnt_d            = CNT_W'(1);
      end
    end

    // Pending flushes merge; an empty buffer has nothing to flush.
    flush_req_d = (flush | flush_req_q) & ~handoff & (merged_cnt != '0);
    overflow_d  = drop | (overflow_q & ~overflow_clr);

    case (state_q)
      ENDED: state_d = ENDED;
      DRAIN: if (~out_valid && (cnt_q == '0)) state_d = ENDED;
      default: begin
        if (test_ending)                              state_d = DRAIN;
        else if (handoff | (out_valid & ~bus.out_ready)) state_d = HOLD;
        else if (cnt_d != '0)                         state_d = FILL;
        else                                          state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      cnt_q       <= '0;
      flush_req_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      flush_req_q <= flush_req_d;
      overflow_q  <= overflow_d;
    end
  end

endmodule

// File: tb/tb_nios_system_cpu_dct_ctrl.sv
// Purpose: self-checking bench for nios_system_cpu_dct_ctrl. Two instances
//          (backpressure and drop-on-full) share one directed stimulus; a
//          symbol-list model predicts both every cycle, and literal checks
//          pin the model at key points.
module tb_nios_system_cpu_dct_ctrl;

  logic       clk;
  logic       reset;
  logic       trace_en, flush, test_ending, overflow_clr;
  logic       sym_valid, out_ready;
  logic [1:0] sym_data;

  logic [29:0] dct_buffer0, dct_buffer1;
  logic [3:0]  dct_count0, dct_count1;
  logic        overflow0, overflow1, ended0, ended1;

  int n_tests = 0;
  int n_fail  = 0;

  nios_system_cpu_dct_ctrl_if if0 ();
  nios_system_cpu_dct_ctrl_if if1 ();

  assign if0.sym_valid = sym_valid;
  assign if0.sym_data  = sym_data;
  assign if0.out_ready = out_ready;
  assign if1.sym_valid = sym_valid;
  assign if1.sym_data  = sym_data;
  assign if1.out_ready = out_ready;

  nios_system_cpu_dct_ctrl #(.DROP_ON_FULL(1'b0)) dut0 (
    .clk(clk), .reset(reset), .trace_en(trace_en), .flush(flush),
    .test_ending(test_ending), .overflow_clr(overflow_clr), .bus(if0),
    .dct_buffer(dct_buffer0), .dct_count(dct_count0),
    .overflow(overflow0), .test_has_ended(ended0)
  );

  nios_system_cpu_dct_ctrl #(.DROP_ON_FULL(1'b1)) dut1 (
    .clk(clk), .reset(reset), .trace_en(trace_en), .flush(flush),
    .test_ending(test_ending), .overflow_clr(overflow_clr), .bus(if1),
    .dct_buffer(dct_buffer1), .dct_count(dct_count1),
    .overflow(overflow1), .test_has_ended(ended1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state per instance: symbol lists for fill buffer and held word.
  typedef struct {
    int fill[16];
    int fcnt;
    int outs[16];
    int ocnt;
    bit ov;
    bit fr;
    bit ovf;
    bit drn;
    bit ended;
  } mdl_t;

  mdl_t m[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pack(input int s[16], input int n);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < n; k++) v = v | (64'(s[k]) << (2 * k));
    return v;
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < 2; i++) begin
      m[i].fcnt = 0; m[i].ocnt = 0; m[i].ov = 0; m[i].fr = 0;
      m[i].ovf = 0;  m[i].drn = 0;  m[i].ended = 0;
      for (int k = 0; k < 16; k++) begin
        m[i].fill[k] = 0;
        m[i].outs[k] = 0;
      end
    end
  endtask

  // Advance one clock: returns the ready the packer must show this cycle.
  task automatic mdl_step(input int i, output bit rdy);
    bit drop_mode, acc, force_f, free, over, hand, dropped;
    int tmp[16];
    int tn;
    drop_mode = (i == 1);
    rdy = trace_en && !test_ending && !m[i].drn && !m[i].ended &&
          (m[i].fcnt < 15 || !m[i].ov || out_ready || drop_mode);
    acc     = sym_valid && rdy;
    force_f = flush || m[i].fr || test_ending || m[i].drn;
    free    = !m[i].ov || out_ready;
    tmp     = m[i].fill;
    tn      = m[i].fcnt;
    over    = acc && (tn == 15);
    if (acc && tn < 15) begin
      tmp[tn] = int'(sym_data);
      tn++;
    end
    hand    = (tn > 0) && (tn == 15 || force_f) && free;
    dropped = over && !hand;
    if (!m[i].ended) begin
      if (m[i].drn) begin
        if (!m[i].ov && m[i].fcnt == 0) m[i].ended = 1;
      end else if (test_ending) begin
        m[i].drn = 1;
      end
    end
    m[i].fr = (flush || m[i].fr) && !hand && (tn > 0);
    if (m[i].ov && out_ready) m[i].ov = 0;
    if (hand) begin
      m[i].outs = tmp;
      m[i].ocnt = tn;
      m[i].ov   = 1;
      tn        = 0;
      if (over) begin
        tmp[0] = int'(sym_data);
        tn     = 1;
      end
    end
    m[i].fill = tmp;
    m[i].fcnt = tn;
    m[i].ovf  = dropped || (m[i].ovf && !overflow_clr);
  endtask

  task automatic check_inst(input int i, input logic ov, input logic [29:0] od,
                            input logic [3:0] oc, input logic [29:0] db,
                            input logic [3:0] dc, input logic ovf, input logic te);
    string p;
    p = (i == 0) ? "dut0" : "dut1";
    chk({p, " out_valid"}, 64'(ov), 64'(m[i].ov));
    if (m[i].ov) begin
      chk({p, " out_data"},  64'(od), pack(m[i].outs, m[i].ocnt));
      chk({p, " out_count"}, 64'(oc), 64'(m[i].ocnt));
    end
    chk({p, " dct_buffer"},     64'(db),  pack(m[i].fill, m[i].fcnt));
    chk({p, " dct_count"},      64'(dc),  64'(m[i].fcnt));
    chk({p, " overflow"},       64'(ovf), 64'(m[i].ovf));
    chk({p, " test_has_ended"}, 64'(te),  64'(m[i].ended));
  endtask

  // Compare on the falling edge, then advance the model for the next rising edge.
  always @(negedge clk) begin
    bit r0, r1;
    if (reset) mdl_reset();
    check_inst(0, if0.out_valid, if0.out_data, if0.out_count, dct_buffer0, dct_count0, overflow0, ended0);
    check_inst(1, if1.out_valid, if1.out_data, if1.out_count, dct_buffer1, dct_count1, overflow1, ended1);
    if (reset) begin
      r0 = 0;
      r1 = 0;
    end else begin
      mdl_step(0, r0);
      mdl_step(1, r1);
    end
    chk("dut0 sym_ready", 64'(if0.sym_ready), 64'(r0));
    chk("dut1 sym_ready", 64'(if1.sym_ready), 64'(r1));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] t2 [3];
    logic [1:0] t5 [5];
    int k;
    t2 = '{2'd3, 2'd2, 2'd1};
    t5 = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    reset = 1'b1;
    trace_en = 1'b1; flush = 1'b0; test_ending = 1'b0; overflow_clr = 1'b0;
    sym_valid = 1'b0; sym_data = 2'd0; out_ready = 1'b0;
    repeat (3) step();
    chk("reset out_valid", 64'(if0.out_valid), 64'(0));
    chk("reset sym_ready", 64'(if0.sym_ready), 64'(0));
    chk("reset dct_count", 64'(dct_count1), 64'(0));
    reset = 1'b0;
    out_ready = 1'b1;
    step();

    // Full word of 0,1,2,3,... with 1-cycle latency.
    for (int i = 0; i < 15; i++) begin
      sym_valid = 1'b1;
      sym_data  = 2'(i % 4);
      if (i == 14) begin
        #1;
        chk("t1 out_valid before 15th", 64'(if0.out_valid), 64'(0));
      end
      step();
    end
    sym_valid = 1'b0;
    chk("t1 out_valid", 64'(if0.out_valid), 64'(1));
    chk("t1 out_count", 64'(if0.out_count), 64'(15));
    chk("t1 out_data",  64'(if0.out_data),  64'(30'h24E4E4E4));
    chk("t1 dct_count", 64'(dct_count0),    64'(0));
    step();
    chk("t1 consumed", 64'(if0.out_valid), 64'(0));

    // Partial word then flush.
    for (int i = 0; i < 3; i++) begin
      sym_valid = 1'b1;
      sym_data  = t2[i];
      step();
    end
    sym_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t2 out_data",  64'(if0.out_data),  64'(30'h1B));
    chk("t2 out_count", 64'(if0.out_count), 64'(3));
    chk("t2 dct_count", 64'(dct_count0),    64'(0));
    step();

    // Both stages full under backpressure; drop instance loses the 31st.
    out_ready = 1'b0;
    for (int i = 0; i < 31; i++) begin
      sym_valid = 1'b1;
      sym_data  = 2'(i % 4);
      if (i == 30) begin
        #1;
        chk("t3 dut0 sym_ready full", 64'(if0.sym_ready), 64'(0));
        chk("t3 dut1 sym_ready full", 64'(if1.sym_ready), 64'(1));
      end
      step();
    end
    sym_valid = 1'b0;
    chk("t3 held word",      64'(if0.out_data), 64'(30'h24E4E4E4));
    chk("t3 dut0 dct_count", 64'(dct_count0),   64'(15));
    chk("t3 dut0 overflow",  64'(overflow0),    64'(0));
    chk("t3 dut1 overflow",  64'(overflow1),    64'(1));
    out_ready = 1'b1;
    step();
    chk("t3 dut0 second word", 64'(if0.out_data), 64'(30'h13939393));
    chk("t3 dut1 second word", 64'(if1.out_data), 64'(30'h13939393));
    chk("t3 dut1 count",       64'(if1.out_count), 64'(15));
    step();
    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    chk("t3 overflow cleared", 64'(overflow1), 64'(0));

    // Flush on empty buffer; flush coincident with an accept.
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t4 empty flush", 64'(if0.out_valid), 64'(0));
    sym_valid = 1'b1;
    sym_data  = 2'd2;
    flush     = 1'b1;
    step();
    sym_valid = 1'b0;
    flush     = 1'b0;
    chk("t4 coincident count", 64'(if0.out_count), 64'(1));
    chk("t4 coincident data",  64'(if0.out_data),  64'(2));
    step();

    // End-of-test drain with delayed downstream.
    for (int i = 0; i < 5; i++) begin
      sym_valid = 1'b1;
      sym_data  = t5[i];
      step();
    end
    sym_valid   = 1'b0;
    out_ready   = 1'b0;
    test_ending = 1'b1;
    step();
    chk("t5 out_count", 64'(if0.out_count), 64'(5));
    chk("t5 out_data",  64'(if0.out_data),  64'(30'h139));
    repeat (3) step();
    chk("t5 held", 64'(if0.out_valid), 64'(1));
    out_ready   = 1'b1;
    test_ending = 1'b0;
    sym_valid   = 1'b1;
    sym_data    = 2'd1;
    k = 0;
    while (!(ended0 && ended1) && k < 10) begin
      step();
      k++;
    end
    chk("t5 dut0 test_has_ended", 64'(ended0), 64'(1));
    chk("t5 dut1 test_has_ended", 64'(ended1), 64'(1));
    chk("t5 sym_ready after end", 64'(if0.sym_ready), 64'(0));
    sym_valid = 1'b0;

    // Reset with both stages occupied.
    reset = 1'b1;
    step();
    reset     = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sym_valid = 1'b1;
      sym_data  = 2'(3 - (i % 4));
      step();
    end
    sym_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sym_valid = 1'b1;
      sym_data  = 2'd3;
      step();
    end
    sym_valid = 1'b0;
    chk("t6 pre dct_count", 64'(dct_count0),    64'(2));
    chk("t6 pre out_valid", 64'(if0.out_valid), 64'(1));
    reset = 1'b1;
    #1;
    chk("t6 rst dct_count",  64'(dct_count0),    64'(0));
    chk("t6 rst dct_buffer", 64'(dct_buffer0),   64'(0));
    chk("t6 rst out_valid",  64'(if0.out_valid), 64'(0));
    chk("t6 rst sym_ready",  64'(if1.sym_ready), 64'(0));
    chk("t6 rst overflow",   64'(overflow1),     64'(0));
    chk("t6 rst ended",      64'(ended0),        64'(0));
    step();
    reset = 1'b0;
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
